// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared widths, FSM encoding and address helper for the MEM stage
package mem_access_stage_pkg;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int REG_IDX_W = 5;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
      return byte_addr & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the MEM stage and data memory
interface mem_access_stage_if;
   import mem_access_stage_pkg::*;

   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic              mem_ack_i;
   logic [DATA_W-1:0] mem_rdata_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_ack_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_ack_i, mem_rdata_i
   );

endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// rtl/mem_access_stage_mem_wb_reg.sv - MEM/WB pipeline register with load enable and bubble insert
module mem_wb_reg
   import mem_access_stage_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 load_i,
   input  logic                 kill_i,
   input  logic                 regwrite_i,
   input  logic                 memtoreg_i,
   input  logic [ADDR_W-1:0]    alu_result_i,
   input  logic [DATA_W-1:0]    mem_data_i,
   input  logic [REG_IDX_W-1:0] rd_i,
   output logic                 regwrite_o,
   output logic                 memtoreg_o,
   output logic [ADDR_W-1:0]    alu_result_o,
   output logic [DATA_W-1:0]    mem_data_o,
   output logic [REG_IDX_W-1:0] rd_o
);

   // Any edge that does not load is a bubble: only the write enable is cleared.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regwrite_o   <= 1'b0;
         memtoreg_o   <= 1'b0;
         alu_result_o <= '0;
         mem_data_o   <= '0;
         rd_o         <= '0;
      end else if (load_i) begin
         regwrite_o   <= regwrite_i && !kill_i && (rd_i != '0);
         memtoreg_o   <= memtoreg_i;
         alu_result_o <= alu_result_i;
         mem_data_o   <= mem_data_i;
         rd_o         <= rd_i;
      end else begin
         regwrite_o   <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RISC-V MEM stage: data-memory handshake FSM, timeout and MEM/WB register
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 regwrite_i,
   input  logic                 memtoreg_i,
   input  logic                 memread_i,
   input  logic                 memwrite_i,
   input  logic [ADDR_W-1:0]    dm_addr_i,
   input  logic [DATA_W-1:0]    dm_write_i,
   input  logic [REG_IDX_W-1:0] rd_i,
   mem_access_stage_if.master   dmem,
   output logic                 stall_o,
   output logic                 err_o,
   output logic                 regwrite_o,
   output logic                 memtoreg_o,
   output logic [ADDR_W-1:0]    alu_result_o,
   output logic [DATA_W-1:0]    mem_data_o,
   output logic [REG_IDX_W-1:0] rd_o
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              access;
   logic              timeout_hit;
   logic              wb_load;
   logic              wb_kill;
   logic [DATA_W-1:0] wb_data;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end

   assign access      = memread_i | memwrite_i;
   assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      stall_o = 1'b0;
      wb_load = 1'b1;
      wb_kill = 1'b0;
      wb_data = '0;
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               stall_o = 1'b1;
               wb_load = 1'b0;
               state_d = ST_BUSY;
               req_d   = 1'b1;
               we_d    = memwrite_i;
               addr_d  = word_addr(dm_addr_i);
               wdata_d = dm_write_i;
               cnt_d   = '0;
            end
         end
         ST_BUSY: begin
            // Ack takes priority over a timeout landing in the same cycle.
            if (dmem.mem_ack_i) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               cnt_d   = '0;
               wb_data = we_q ? '0 : dmem.mem_rdata_i;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               cnt_d   = '0;
               err_d   = 1'b1;
               wb_kill = 1'b1;
            end else begin
               stall_o = 1'b1;
               wb_load = 1'b0;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign dmem.mem_req_o   = req_q;
   assign dmem.mem_we_o    = we_q;
   assign dmem.mem_addr_o  = addr_q;
   assign dmem.mem_wdata_o = wdata_q;
   assign err_o            = err_q;

   mem_wb_reg u_mem_wb_reg (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (wb_load),
      .kill_i       (wb_kill),
      .regwrite_i   (regwrite_i),
      .memtoreg_i   (memtoreg_i),
      .alu_result_i (dm_addr_i),
      .mem_data_i   (wb_data),
      .rd_i         (rd_i),
      .regwrite_o   (regwrite_o),
      .memtoreg_o   (memtoreg_o),
      .alu_result_o (alu_result_o),
      .mem_data_o   (mem_data_o),
      .rd_o         (rd_o)
   );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic        regwrite_i, memtoreg_i, memread_i, memwrite_i;
   logic [31:0] dm_addr_i, dm_write_i;
   logic [4:0]  rd_i;
   logic        stall_o, err_o, regwrite_o, memtoreg_o;
   logic [31:0] alu_result_o, mem_data_o;
   logic [4:0]  rd_o;

   int checks = 0;
   int failures = 0;
   logic err_m;

   mem_access_stage_if dmem ();

   mem_access_stage #(.TIMEOUT(TO)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .regwrite_i   (regwrite_i),
      .memtoreg_i   (memtoreg_i),
      .memread_i    (memread_i),
      .memwrite_i   (memwrite_i),
      .dm_addr_i    (dm_addr_i),
      .dm_write_i   (dm_write_i),
      .rd_i         (rd_i),
      .dmem         (dmem),
      .stall_o      (stall_o),
      .err_o        (err_o),
      .regwrite_o   (regwrite_o),
      .memtoreg_o   (memtoreg_o),
      .alu_result_o (alu_result_o),
      .mem_data_o   (mem_data_o),
      .rd_o         (rd_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rw, mtr, rd, wr;
      logic [31:0] addr, wdata, rdata;
      logic [4:0]  rdx;
      int          lat;
      logic        stray;
      logic        e_rw;
      logic [31:0] e_data;
      int          e_stall;
      logic        e_err;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a load/store costs lat stall cycles unless the memory is slower than TO,
   // in which case it costs TO cycles, is retired without a register write and sets err.
   function automatic vec_t model(input vec_t v, input logic err_prev);
      vec_t r = v;
      r.e_rw    = v.rw && (v.rdx != 5'd0);
      r.e_data  = 32'h0;
      r.e_stall = 0;
      r.e_err   = err_prev;
      if (v.rd || v.wr) begin
         if (v.lat <= TO) begin
            r.e_stall = v.lat;
            if (!v.wr) r.e_data = v.rdata;
         end else begin
            r.e_stall = TO;
            r.e_rw    = 1'b0;
            r.e_err   = 1'b1;
         end
      end
      return r;
   endfunction

   // Called at posedge+1; acts as the data memory and leaves at posedge+1 after retirement.
   task automatic run_instr(input vec_t v);
      int b = 0;
      int nstall = 0;
      logic done = 1'b0;
      regwrite_i = v.rw;  memtoreg_i = v.mtr;  memread_i = v.rd;  memwrite_i = v.wr;
      dm_addr_i  = v.addr; dm_write_i = v.wdata; rd_i = v.rdx;
      dmem.mem_rdata_i = v.rdata;
      chk("req_low_at_issue", 32'(dmem.mem_req_o), 32'h0);
      for (int k = 0; k < 40 && !done; k++) begin
         if (dmem.mem_req_o) b++;
         dmem.mem_ack_i = (dmem.mem_req_o && b == v.lat) || (v.stray && k == 0);
         @(negedge clk);
         if (dmem.mem_req_o) begin
            chk("mem_addr", dmem.mem_addr_o, {v.addr[31:2], 2'b00});
            chk("mem_wdata", dmem.mem_wdata_o, v.wdata);
            chk("mem_we", 32'(dmem.mem_we_o), 32'(v.wr));
         end
         if (k > 0) chk("bubble_regwrite", 32'(regwrite_o), 32'h0);
         if (stall_o) nstall++;
         else done = 1'b1;
         @(posedge clk); #1;
      end
      dmem.mem_ack_i = 1'b0;
      chk("retired", 32'(done), 32'h1);
      chk("stall_cycles", 32'(nstall), 32'(v.e_stall));
      chk("regwrite_o", 32'(regwrite_o), 32'(v.e_rw));
      chk("memtoreg_o", 32'(memtoreg_o), 32'(v.mtr));
      chk("alu_result_o", alu_result_o, v.addr);
      chk("mem_data_o", mem_data_o, v.e_data);
      chk("rd_o", 32'(rd_o), 32'(v.rdx));
      chk("err_o", 32'(err_o), 32'(v.e_err));
   endtask

   initial begin
      vec_t v;
      int kind;
      rst = 1'b1;
      regwrite_i = 1'b0; memtoreg_i = 1'b0; memread_i = 1'b0; memwrite_i = 1'b0;
      dm_addr_i = 32'h0; dm_write_i = 32'h0; rd_i = 5'd0;
      dmem.mem_ack_i = 1'b0; dmem.mem_rdata_i = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_stall", 32'(stall_o), 32'h0);
      chk("rst_req", 32'(dmem.mem_req_o), 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      chk("rst_regwrite", 32'(regwrite_o), 32'h0);
      chk("rst_alu_result", alu_result_o, 32'h0);
      chk("rst_mem_data", mem_data_o, 32'h0);
      @(posedge clk); #1;

      //         rw    mtr   rd    wr    addr          wdata         rdata         rdx  lat stray e_rw  e_data        stall e_err
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0,        32'h0,        5'd5, 1, 1'b0, 1'b1, 32'h0,        0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'h0,        32'hCAFE_F00D, 5'd7, 4, 1'b0, 1'b1, 32'hCAFE_F00D, 4, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0055, 32'h0000_9999, 5'd0, 2, 1'b0, 1'b0, 32'h0,        2, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        32'h1111_2222, 5'd0, 1, 1'b0, 1'b0, 32'h1111_2222, 1, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'hA5A5_A5A5, 32'h0,        5'd0, 1, 1'b0, 1'b0, 32'h0,        1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0,        32'hFFFF_FFFF, 5'd0, 1, 1'b1, 1'b0, 32'h0,        0, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0,        32'h0000_0BAD, 5'd9, 5, 1'b0, 1'b0, 32'h0,        4, 1'b1};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0005, 32'h0,        32'h0000_0BAD, 5'd3, 1, 1'b1, 1'b1, 32'h0,        0, 1'b1};
      tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0402, 32'h1234_5678, 32'h0000_EEEE, 5'd4, 3, 1'b0, 1'b1, 32'h0,        3, 1'b1};
      for (int i = 0; i < 9; i++) run_instr(tbl[i]);

      // Reset while a request is outstanding, then a stray ack.
      regwrite_i = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0; memtoreg_i = 1'b1;
      rd_i = 5'd3; dm_addr_i = 32'h500;
      @(posedge clk); #1;
      chk("busy_req", 32'(dmem.mem_req_o), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      regwrite_i = 1'b0; memread_i = 1'b0; memtoreg_i = 1'b0; rd_i = 5'd0; dm_addr_i = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstbusy_req", 32'(dmem.mem_req_o), 32'h0);
      chk("rstbusy_stall", 32'(stall_o), 32'h0);
      chk("rstbusy_err", 32'(err_o), 32'h0);
      chk("rstbusy_regwrite", 32'(regwrite_o), 32'h0);
      chk("rstbusy_memtoreg", 32'(memtoreg_o), 32'h0);
      chk("rstbusy_rd", 32'(rd_o), 32'h0);
      chk("rstbusy_addr", dmem.mem_addr_o, 32'h0);
      @(posedge clk); #1;
      dmem.mem_ack_i = 1'b1; dmem.mem_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("stray_ack_stall", 32'(stall_o), 32'h0);
      @(posedge clk); #1;
      dmem.mem_ack_i = 1'b0;
      @(negedge clk);
      chk("stray_ack_req", 32'(dmem.mem_req_o), 32'h0);
      chk("stray_ack_data", mem_data_o, 32'h0);
      @(posedge clk); #1;
      err_m = 1'b0;

      for (int n = 0; n < 60; n++) begin
         kind    = int'($urandom_range(0, 7));
         v.rw    = 1'($urandom_range(0, 1));
         v.mtr   = 1'($urandom_range(0, 1));
         v.rd    = (kind == 4 || kind == 5 || kind == 7);
         v.wr    = (kind == 6 || kind == 7);
         v.addr  = $urandom;
         v.wdata = $urandom;
         v.rdata = $urandom;
         v.rdx   = 5'($urandom_range(0, 31));
         v.lat   = int'($urandom_range(1, 6));
         v.stray = ($urandom_range(0, 4) == 0);
         v = model(v, err_m);
         err_m = v.e_err;
         run_instr(v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
